// File: rtl/lsu_access_sequencer_pkg.sv
// lsu_pkg: shared access-type and FSM state encodings for the load/store sequencer.
package lsu_pkg;
    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;
    function automatic logic [2:0] access_bytes(input logic [2:0] ctrl);
        return ctrl[1] ? 3'd4 : (ctrl[0] ? 3'd2 : 3'd1);
    endfunction
endpackage

// File: rtl/lsu_access_sequencer_if.sv
// lsu_access_sequencer_if: request/response handshake plus data-memory bus of the sequencer.
interface lsu_access_sequencer_if;
    logic        ReqValid, ReqReady, ReqWr, RspValid, RspErr, DMWr;
    logic [31:0] ReqAddr, ReqWrData, RspData, DMAddress, DMDataWr, DMDataRd;
    logic [2:0]  ReqCtrl, DMCtrl;
    modport master (
        output ReqValid, ReqAddr, ReqWrData, ReqWr, ReqCtrl, DMDataRd,
        input  ReqReady, RspValid, RspData, RspErr, DMAddress, DMDataWr, DMWr, DMCtrl
    );
    modport slave (
        input  ReqValid, ReqAddr, ReqWrData, ReqWr, ReqCtrl, DMDataRd,
        output ReqReady, RspValid, RspData, RspErr, DMAddress, DMDataWr, DMWr, DMCtrl
    );
endinterface

// File: rtl/lsu_access_sequencer_load_extend.sv
// lsu_load_extend: extends a byte-assembled split load to 32 bits by access type.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] bytes_in,
    input  logic [2:0]  ctrl,
    output logic [31:0] result
);
    always_comb
        result = (ctrl == DM_H)  ? {{16{bytes_in[15]}}, bytes_in[15:0]} :
                 (ctrl == DM_HU) ? {16'h0, bytes_in[15:0]} : bytes_in;
endmodule

// File: rtl/lsu_access_sequencer.sv
// lsu_access_sequencer: issues load/store requests to data memory, splitting misaligned ones into byte beats.
// Define MISALIGN_TRAP_EN to reject misaligned H/HU/W requests with an error instead of splitting them.
module lsu_access_sequencer
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input logic                   clk,
    input logic                   rst_n,
    lsu_access_sequencer_if.slave bus
);
    lsu_state_e  state_q, state_d;
    logic [31:0] data_q, data_d, dm_addr_q, dm_addr_d, dm_data_q, dm_data_d;
    logic [31:0] rsp_q, rsp_d, asm_q, asm_d;
    logic [2:0]  ctrl_q, ctrl_d, dm_ctrl_q, dm_ctrl_d, nbytes;
    logic [1:0]  beat_q, beat_d, last_q, last_d;
    logic        wr_q, wr_d, err_q, err_d;
    logic        aligned, bad_ctrl, out_of_range, req_err;

    always_comb begin
        nbytes       = access_bytes(bus.ReqCtrl);
        bad_ctrl     = (bus.ReqCtrl inside {3'b011, 3'b110, 3'b111}) || (bus.ReqWr && bus.ReqCtrl[2]);
        aligned      = (nbytes == 3'd1) || (nbytes == 3'd2 && !bus.ReqAddr[0]) ||
                       (nbytes == 3'd4 && bus.ReqAddr[1:0] == 2'b00);
        // 33-bit sum so an access wrapping past 0xFFFFFFFF also lands out of range
        out_of_range = ({1'b0, bus.ReqAddr} + 33'(nbytes) - 33'd1) >= 33'(MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
        req_err      = bad_ctrl || out_of_range || !aligned;
`else
        req_err      = bad_ctrl || out_of_range;
`endif
    end

`ifdef MISALIGN_TRAP_EN
`else
    logic [31:0] asm_nx, ext_res;
    always_comb begin
        asm_nx = asm_q;
        asm_nx[{beat_q, 3'b000} +: 8] = bus.DMDataRd[7:0];
    end
    lsu_load_extend u_ext (.bytes_in(asm_nx), .ctrl(ctrl_q), .result(ext_res));
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        wr_d      = wr_q;
        ctrl_d    = ctrl_q;
        beat_d    = beat_q;
        last_d    = last_q;
        err_d     = err_q;
        rsp_d     = rsp_q;
        asm_d     = asm_q;
        dm_addr_d = dm_addr_q;
        dm_data_d = dm_data_q;
        dm_ctrl_d = dm_ctrl_q;
        case (state_q)
            IDLE: if (bus.ReqValid) begin
                data_d  = bus.ReqWrData;
                wr_d    = bus.ReqWr;
                ctrl_d  = bus.ReqCtrl;
                beat_d  = 2'd0;
                last_d  = aligned ? 2'd0 : 2'(nbytes - 3'd1);
                err_d   = req_err;
                rsp_d   = '0;
                state_d = req_err ? RESP : ACCESS;
                if (!req_err) begin
                    dm_addr_d = bus.ReqAddr;
                    dm_ctrl_d = aligned ? bus.ReqCtrl : (bus.ReqWr ? DM_B : DM_BU);
                    dm_data_d = aligned ? bus.ReqWrData : {24'h0, bus.ReqWrData[7:0]};
                end
            end
            ACCESS: begin
`ifdef MISALIGN_TRAP_EN
                state_d = RESP;
                rsp_d   = wr_q ? '0 : bus.DMDataRd;
`else
                beat_d = beat_q + 2'd1;
                asm_d  = asm_nx;
                if (beat_q == last_q) begin
                    state_d = RESP;
                    rsp_d   = wr_q ? '0 : ((last_q != 2'd0) ? ext_res : bus.DMDataRd);
                end else begin
                    dm_addr_d = dm_addr_q + 32'd1;
                    dm_data_d = {24'h0, data_q[{beat_d, 3'b000} +: 8]};
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            wr_q      <= 1'b0;
            ctrl_q    <= '0;
            beat_q    <= '0;
            last_q    <= '0;
            err_q     <= 1'b0;
            rsp_q     <= '0;
            asm_q     <= '0;
            dm_addr_q <= '0;
            dm_data_q <= '0;
            dm_ctrl_q <= DM_W;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            ctrl_q    <= ctrl_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            err_q     <= err_d;
            rsp_q     <= rsp_d;
            asm_q     <= asm_d;
            dm_addr_q <= dm_addr_d;
            dm_data_q <= dm_data_d;
            dm_ctrl_q <= dm_ctrl_d;
        end
    end

    // Write enable is decoded from state so an async reset drops it immediately
    assign bus.DMWr      = (state_q == ACCESS) && wr_q;
    assign bus.ReqReady  = state_q == IDLE;
    assign bus.RspValid  = state_q == RESP;
    assign bus.RspErr    = (state_q == RESP) && err_q;
    assign bus.RspData   = (state_q == RESP) ? rsp_q : '0;
    assign bus.DMAddress = dm_addr_q;
    assign bus.DMDataWr  = dm_data_q;
    assign bus.DMCtrl    = dm_ctrl_q;
endmodule
